// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared defaults and address-width helper for the scoreboarded register file.
package regfile_scoreboard_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_REGS = 4;
  function automatic int aw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write flags, reservation acceptance and registered busy count.
module rf_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 0,
  localparam int AW = aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                write,
  input  logic [AW-1:0]       write_reg,
  input  logic                reserve,
  input  logic [AW-1:0]       reserve_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                reserve_ok,
  output logic [AW:0]         busy_count
);
  logic [NUM_REGS-1:0] busy_nxt;
  logic [AW:0] cnt_nxt;
  assign reserve_ok = reset_n && reserve && !busy[reserve_reg];
  // reserve is applied after the write-clear so a same-register reservation wins
  always_comb begin
    busy_nxt = busy;
    if (write) busy_nxt[write_reg] = 1'b0;
    if (reserve_ok) busy_nxt[reserve_reg] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt += (AW+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      busy <= '0;
      busy_count <= '0;
    end else begin
      busy <= busy_nxt;
      busy_count <= cnt_nxt;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two-read one-write register file with write forwarding and a reservation scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 0,
  parameter int BYPASS = 1,
  localparam int AW = aw(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     read_reg1,
  input  logic [AW-1:0]     read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic              write,
  input  logic [AW-1:0]     write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reserve,
  input  logic [AW-1:0]     reserve_reg,
  output logic              reserve_ok,
  output logic [AW:0]       busy_count
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic zero1, zero2, fwd1, fwd2;
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .reset_n(reset_n), .write(write), .write_reg(write_reg),
    .reserve(reserve), .reserve_reg(reserve_reg), .busy(busy),
    .reserve_ok(reserve_ok), .busy_count(busy_count)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (write && !(ZERO_REG != 0 && write_reg == '0)) mem[write_reg] <= write_data;
  assign zero1 = ZERO_REG != 0 && read_reg1 == '0;
  assign zero2 = ZERO_REG != 0 && read_reg2 == '0;
  assign fwd1 = BYPASS != 0 && write && write_reg == read_reg1;
  assign fwd2 = BYPASS != 0 && write && write_reg == read_reg2;
  assign read_data1 = zero1 ? '0 : fwd1 ? write_data : mem[read_reg1];
  assign read_data2 = zero2 ? '0 : fwd2 ? write_data : mem[read_reg2];
  assign read_busy1 = !zero1 && !fwd1 && busy[read_reg1];
  assign read_busy2 = !zero2 && !fwd2 && busy[read_reg2];
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 4, register count, a power of two and at least 2; AW = log2(NUM_REGS).
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle write data forwards to the read ports.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have ports read_reg1 and read_reg2, input, AW bits each, read addresses.
REQ-008 The block SHALL have ports read_data1 and read_data2, output, DATA_W bits each, read data.
REQ-009 The block SHALL have ports read_busy1 and read_busy2, output, 1 bit each, pending-write flag of the addressed register.
REQ-010 The block SHALL have ports write, input, 1 bit; write_reg, input, AW bits; write_data, input, DATA_W bits; together the write-back port.
REQ-011 The block SHALL have ports reserve, input, 1 bit, and reserve_reg, input, AW bits, which mark a register as pending a write.
REQ-012 The block SHALL have port reserve_ok, output, 1 bit, high when the requested reservation is accepted this cycle.
REQ-013 The block SHALL have port busy_count, output, AW+1 bits, the number of busy registers.

Function
REQ-014 Reads SHALL be combinational with zero cycles of latency from address to data.
REQ-015 With BYPASS=1, when write is high and write_reg equals read_regN, read_dataN SHALL equal write_data and read_busyN SHALL read 0 (the write clears the pending flag).
REQ-016 With BYPASS=0, reads SHALL return the stored value and the stored busy bit; a write becomes visible on the cycle after the edge.
REQ-017 With ZERO_REG=1, an address of 0 SHALL read data 0 and busy 0 regardless of write, reserve or bypass.
REQ-018 A write with write=1 SHALL store write_data into write_reg and clear busy[write_reg] at the rising edge.
REQ-019 reserve_ok SHALL equal reserve AND NOT busy[reserve_reg] (stored value); a second reservation of a busy register SHALL be refused.
REQ-020 An accepted reservation SHALL set busy[reserve_reg] at the edge.
REQ-021 On simultaneous write and accepted reserve to the same register, the data SHALL be stored and busy SHALL end up 1 (reserve wins).
REQ-022 On simultaneous write to register A and reserve of a busy register A, reserve_ok SHALL be 0; busy clears and data is stored.
REQ-023 With ZERO_REG=1, a reservation of register 0 SHALL give reserve_ok=1 and leave busy unchanged.
REQ-024 busy_count SHALL be a registered population count of the busy bits, consistent with them on every cycle; it SHALL never exceed NUM_REGS.
REQ-025 A write to a non-busy register SHALL be legal and leave busy unchanged at 0.

Reset
REQ-026 Asserting reset_n low SHALL, asynchronously, clear all registers to 0, all busy bits to 0 and busy_count to 0.
REQ-027 During reset, the read outputs SHALL reflect the cleared state (data 0, busy 0, with bypass still active) and reserve_ok SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard all pending reservations; no state SHALL change until the first rising clk edge after reset_n deasserts.

Structure
REQ-029 A shared package SHALL hold the default DATA_W and NUM_REGS constants and an AW helper function (clog2).
REQ-030 The block SHALL contain one sub-module, rf_scoreboard, owning the busy vector, the reserve_ok logic and busy_count; the data array and bypass logic SHALL live in the top level.

Verification
REQ-031 Scenario, reset then readback: hold reset_n low, release, read all addresses -> data 0x00, busy 0, busy_count 0.
REQ-032 Scenario, bypass: write reg2=0xA5 with read_reg1=2 in the same cycle -> read_data1=0xA5 (BYPASS=1), or the old value with 0xA5 on the next cycle (BYPASS=0).
REQ-033 Scenario, reservation: reserve reg1 -> reserve_ok=1, busy_count=1, read_busy=1; reserve reg1 again -> reserve_ok=0; write reg1=0x3C -> busy clears, busy_count=0, data 0x3C.
REQ-034 Scenario, same-cycle write and reserve: both on reg3 (not busy) with data 0x77 -> next cycle data 0x77, busy[3]=1.
REQ-035 Scenario, zero register (ZERO_REG=1): write reg0=0xFF and reserve reg0 -> read 0x00, busy 0, reserve_ok=1, busy_count unchanged.
REQ-036 Scenario, reset mid-operation: with 3 registers busy and data nonzero, pulse reset_n low between edges -> immediate data 0, busy 0, busy_count 0.
